gshare_pattern_table: RTL and testbench

//  Consumer of the global-history shift register. It holds a gshare pattern history table
//  of 2-bit saturating counters.
//  - Predict port: hashes fetch PC with speculative history (new_output side of history reg)
//    and returns a registered taken/not-taken prediction plus the index it used.
//  - Update port: the resolve stage returns that index with the actual outcome.

---
 rtl/bp_pkg.sv | 23 ++
 rtl/gshare_pattern_table_if.sv | 36 +++
 rtl/sat_counter2.sv | 30 +++
 rtl/gshare_pattern_table.sv | 135 +++++++++++++
 tb/tb_gshare_pattern_table.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared branch-predictor types used by the gshare pattern table and its
// saturating-counter helper.
//   ctr2_t       2-bit saturating counter type
//   CTR_SNT..ST  strongly/weakly not-taken, weakly/strongly taken encodings
//   pht_state_e  pattern-table controller states (init sweep, normal run)
// ---------------------------------------------------------------------------
package bp_pkg;

    typedef logic [1:0] ctr2_t;

    localparam ctr2_t CTR_SNT = 2'd0;
    localparam ctr2_t CTR_WNT = 2'd1;
    localparam ctr2_t CTR_WT  = 2'd2;
    localparam ctr2_t CTR_ST  = 2'd3;

    typedef enum logic {
        PHT_INIT,
        PHT_RUN
    } pht_state_e;

endpackage

// File: rtl/gshare_pattern_table_if.sv
// ---------------------------------------------------------------------------
// gshare_pattern_table_if
// Predict/update bundle between fetch (master) and the pattern table (slave).
//   pred_req/pred_pc/pred_history   prediction request from fetch
//   ready                           table initialised, requests accepted
//   pred_valid/pred_taken/pred_index registered prediction result
//   upd_valid/upd_index/upd_taken   resolved branch outcome from resolve stage
// ---------------------------------------------------------------------------
interface gshare_pattern_table_if #(
    parameter int N = 9
);

    logic          pred_req;
    logic [31:0]   pred_pc;
    logic [N-1:0]  pred_history;
    logic          ready;
    logic          pred_valid;
    logic          pred_taken;
    logic [N-1:0]  pred_index;
    logic          upd_valid;
    logic [N-1:0]  upd_index;
    logic          upd_taken;

    modport master (
        output pred_req, pred_pc, pred_history,
        output upd_valid, upd_index, upd_taken,
        input  ready, pred_valid, pred_taken, pred_index
    );

    modport slave (
        input  pred_req, pred_pc, pred_history,
        input  upd_valid, upd_index, upd_taken,
        output ready, pred_valid, pred_taken, pred_index
    );

endinterface

// File: rtl/sat_counter2.sv
// ---------------------------------------------------------------------------
// sat_counter2
// Combinational next value of a 2-bit saturating counter.
//   ctr_in   current counter value
//   taken    branch outcome: count up when 1, down when 0
//   ctr_out  next value, clamped at 0 and 3 (never wraps)
// ---------------------------------------------------------------------------
module sat_counter2
    import bp_pkg::*;
(
    input  ctr2_t ctr_in,
    input  logic  taken,
    output ctr2_t ctr_out
);

    // Step toward the outcome unless already pinned at that end of the range.
    always_comb begin
        ctr_out = ctr_in;
        if (taken) begin
            if (ctr_in != CTR_ST) begin
                ctr_out = ctr_in + 2'd1;
            end
        end else begin
            if (ctr_in != CTR_SNT) begin
                ctr_out = ctr_in - 2'd1;
            end
        end
    end

endmodule

// File: rtl/gshare_pattern_table.sv
// ---------------------------------------------------------------------------
// gshare_pattern_table
// Gshare pattern history table of 2**N two-bit saturating counters.
// Fetch PC bits are XORed with speculative global history to pick a counter;
// its MSB is returned one cycle later as the prediction, together with the
// index so the resolve stage can train that same counter.
//   clk    single clock, all state on posedge
//   reset  synchronous, active-high; restarts the init sweep
//   bus    slave side of gshare_pattern_table_if (predict + update ports)
// ---------------------------------------------------------------------------
module gshare_pattern_table
    import bp_pkg::*;
#(
    parameter int    N        = 9,
    parameter int    PC_LSB   = 2,
    parameter ctr2_t INIT_CTR = CTR_WNT
) (
    input logic                    clk,
    input logic                    reset,
    gshare_pattern_table_if.slave  bus
);

    pht_state_e    state_q, state_d;
    logic [N-1:0]  init_ptr_q, init_ptr_d;
    logic          ready_q;
    logic          pred_valid_q;
    logic          pred_taken_q;
    logic [N-1:0]  pred_index_q;

    ctr2_t         pht_q [2**N];

    logic [N-1:0]  pred_idx;
    logic          run;
    logic          req_acc;
    logic          upd_acc;
    ctr2_t         upd_ctr;
    ctr2_t         rd_ctr;
    logic          we;
    logic [N-1:0]  waddr;
    ctr2_t         wdata;
    logic          unused_pc;

    assign pred_idx  = bus.pred_pc[PC_LSB+N-1:PC_LSB] ^ bus.pred_history;
    assign unused_pc = ^{bus.pred_pc[31:PC_LSB+N], bus.pred_pc[PC_LSB-1:0]};

    // Requests and updates are only honoured once the sweep has finished.
    assign run     = (state_q == PHT_RUN);
    assign req_acc = run & bus.pred_req;
    assign upd_acc = run & bus.upd_valid;

    sat_counter2 u_sat (
        .ctr_in  (pht_q[bus.upd_index]),
        .taken   (bus.upd_taken),
        .ctr_out (upd_ctr)
    );

    // Write-first bypass: a prediction hitting the entry being trained this
    // cycle sees the post-update counter rather than the stale array value.
    always_comb begin
        rd_ctr = pht_q[pred_idx];
        if (upd_acc && (bus.upd_index == pred_idx)) begin
            rd_ctr = upd_ctr;
        end
    end

    // Init sweep walks every entry once, then the controller parks in RUN
    // until the next reset.
    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        case (state_q)
            PHT_INIT: begin
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == {N{1'b1}}) begin
                    state_d = PHT_RUN;
                end
            end
            PHT_RUN: begin
                state_d = PHT_RUN;
            end
            default: begin
                state_d = PHT_INIT;
            end
        endcase
    end

    // Single table write port shared between the init sweep and training.
    always_comb begin
        we    = 1'b0;
        waddr = init_ptr_q;
        wdata = INIT_CTR;
        if (state_q == PHT_INIT) begin
            we = 1'b1;
        end else if (upd_acc) begin
            we    = 1'b1;
            waddr = bus.upd_index;
            wdata = upd_ctr;
        end
    end

    // Table storage has no reset; the sweep after reset defines its contents.
    always_ff @(posedge clk) begin
        if (we && !reset) begin
            pht_q[waddr] <= wdata;
        end
    end

    // Controller state and the registered prediction outputs. Taken/index
    // only move on an accepted request so they hold while pred_valid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= PHT_INIT;
            init_ptr_q   <= '0;
            ready_q      <= 1'b0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_index_q <= '0;
        end else begin
            state_q      <= state_d;
            init_ptr_q   <= init_ptr_d;
            ready_q      <= (state_d == PHT_RUN);
            pred_valid_q <= req_acc;
            if (req_acc) begin
                pred_taken_q <= rd_ctr[1];
                pred_index_q <= pred_idx;
            end
        end
    end

    assign bus.ready      = ready_q;
    assign bus.pred_valid = pred_valid_q;
    assign bus.pred_taken = pred_taken_q;
    assign bus.pred_index = pred_index_q;

endmodule

// File: tb/tb_gshare_pattern_table.sv
// ---------------------------------------------------------------------------
// tb_gshare_pattern_table
// Directed checks on an N=4 table (init timing, hashing, saturation, bypass,
// reset mid-sweep) plus a randomised run on an N=9 table against a counter
// model. Expected predictions are queued when requests are issued and popped
// by a monitor whenever the table presents pred_valid.
// ---------------------------------------------------------------------------
module tb_gshare_pattern_table;

    typedef struct packed {
        logic       taken;
        logic [8:0] index;
    } exp_t;

    logic clk = 1'b0;
    logic reset4 = 1'b1;
    logic reset9 = 1'b1;

    int vectors = 0;
    int miscompares = 0;

    exp_t q4[$];
    exp_t q9[$];
    logic [1:0] m9 [512];

    gshare_pattern_table_if #(.N(4)) bus4 ();
    gshare_pattern_table_if #(.N(9)) bus9 ();

    gshare_pattern_table #(.N(4), .PC_LSB(2), .INIT_CTR(2'b01)) dut4 (
        .clk   (clk),
        .reset (reset4),
        .bus   (bus4)
    );

    gshare_pattern_table #(.N(9), .PC_LSB(2), .INIT_CTR(2'b01)) dut9 (
        .clk   (clk),
        .reset (reset9),
        .bus   (bus9)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor for the N=4 table: every valid prediction must match the next
    // queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus4.pred_valid === 1'b1) begin
            if (q4.size() == 0) begin
                checkOutput("pred4_unexpected", 32'd1, 32'd0);
            end else begin
                e = q4.pop_front();
                checkOutput("pred4_taken", 32'(bus4.pred_taken), 32'(e.taken));
                checkOutput("pred4_index", 32'(bus4.pred_index), 32'(e.index));
            end
        end
    end

    // Monitor for the N=9 table.
    always @(negedge clk) begin
        exp_t e;
        if (bus9.pred_valid === 1'b1) begin
            if (q9.size() == 0) begin
                checkOutput("pred9_unexpected", 32'd1, 32'd0);
            end else begin
                e = q9.pop_front();
                checkOutput("pred9_taken", 32'(bus9.pred_taken), 32'(e.taken));
                checkOutput("pred9_index", 32'(bus9.pred_index), 32'(e.index));
            end
        end
    end

    // Drive one cycle of N=4 stimulus at a negedge with hand-computed
    // expectations, then advance to the next negedge.
    task automatic applyStimulus(input logic req, input logic [31:0] pc, input logic [3:0] hist,
                                 input logic upd, input logic [3:0] uidx, input logic utk,
                                 input logic expTaken, input logic [3:0] expIdx);
        bus4.pred_req     = req;
        bus4.pred_pc      = pc;
        bus4.pred_history = hist;
        bus4.upd_valid    = upd;
        bus4.upd_index    = uidx;
        bus4.upd_taken    = utk;
        if (req) begin
            q4.push_back('{taken: expTaken, index: 9'(expIdx)});
        end
        @(negedge clk);
    endtask

    // Reset-state outputs of the N=4 table.
    task automatic checkReset4();
        checkOutput("rst_ready", 32'(bus4.ready), 32'd0);
        checkOutput("rst_pred_valid", 32'(bus4.pred_valid), 32'd0);
        checkOutput("rst_pred_taken", 32'(bus4.pred_taken), 32'd0);
        checkOutput("rst_pred_index", 32'(bus4.pred_index), 32'd0);
    endtask

    // Called at the negedge where reset drops: ready low for exactly 16
    // cycles with no predictions, then high.
    task automatic checkInit4();
        for (int i = 0; i < 16; i++) begin
            checkOutput("init_ready_low", 32'(bus4.ready), 32'd0);
            checkOutput("init_no_valid", 32'(bus4.pred_valid), 32'd0);
            @(negedge clk);
        end
        checkOutput("init_ready_high", 32'(bus4.ready), 32'd1);
        checkOutput("init_no_valid_end", 32'(bus4.pred_valid), 32'd0);
    endtask

    function automatic logic [1:0] satNext(input logic [1:0] c, input logic t);
        if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
        return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    // Watchdog: the run must never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt;
        logic        req, upd, utk;
        logic [31:0] pc;
        logic [8:0]  hist, idx, uidx;

        bus4.pred_req = 1'b0; bus4.pred_pc = '0; bus4.pred_history = '0;
        bus4.upd_valid = 1'b0; bus4.upd_index = '0; bus4.upd_taken = 1'b0;
        bus9.pred_req = 1'b0; bus9.pred_pc = '0; bus9.pred_history = '0;
        bus9.upd_valid = 1'b0; bus9.upd_index = '0; bus9.upd_taken = 1'b0;

        // Test 1: reset 3 cycles, then 16-cycle sweep ignoring req and update.
        repeat (3) @(negedge clk);
        checkReset4();
        bus4.pred_req = 1'b1; bus4.pred_pc = 32'h14; bus4.pred_history = 4'b0011;
        bus4.upd_valid = 1'b1; bus4.upd_index = 4'd6; bus4.upd_taken = 1'b1;
        reset4 = 1'b0;
        checkInit4();

        // Test 2: pc 0x14 ^ hist 0011 -> index 6, weakly not-taken.
        applyStimulus(1, 32'h14, 4'b0011, 0, 4'd0, 0, 1'b0, 4'd6);
        applyStimulus(0, 32'h0, 4'd0, 0, 4'd0, 0, 1'b0, 4'd0);

        // Test 3: saturation with back-to-back updates and same-cycle reads.
        // ctr[6]: 1 -> 2,3,3,3 then 2,1,0,0,0.
        applyStimulus(1, 32'h14, 4'b0011, 1, 4'd6, 1, 1'b1, 4'd6);
        applyStimulus(1, 32'h14, 4'b0011, 1, 4'd6, 1, 1'b1, 4'd6);
        applyStimulus(1, 32'h14, 4'b0011, 1, 4'd6, 1, 1'b1, 4'd6);
        applyStimulus(1, 32'h14, 4'b0011, 1, 4'd6, 1, 1'b1, 4'd6);
        applyStimulus(1, 32'h14, 4'b0011, 1, 4'd6, 0, 1'b1, 4'd6);
        applyStimulus(1, 32'h14, 4'b0011, 1, 4'd6, 0, 1'b0, 4'd6);
        applyStimulus(1, 32'h14, 4'b0011, 1, 4'd6, 0, 1'b0, 4'd6);
        applyStimulus(1, 32'h14, 4'b0011, 1, 4'd6, 0, 1'b0, 4'd6);
        applyStimulus(1, 32'h14, 4'b0011, 1, 4'd6, 0, 1'b0, 4'd6);
        applyStimulus(0, 32'h0, 4'd0, 0, 4'd0, 0, 1'b0, 4'd0);

        // Test 4: ctr[6] 0 -> 1 (read 1: not taken), then bypass 1 -> 2 (taken).
        // Then train 6 to 3 while reading index 8 (untouched, 1), then read 6.
        applyStimulus(0, 32'h0, 4'd0, 1, 4'd6, 1, 1'b0, 4'd0);
        applyStimulus(1, 32'h14, 4'b0011, 0, 4'd0, 0, 1'b0, 4'd6);
        applyStimulus(1, 32'h14, 4'b0011, 1, 4'd6, 1, 1'b1, 4'd6);
        applyStimulus(1, 32'h20, 4'b0000, 1, 4'd6, 1, 1'b0, 4'd8);
        applyStimulus(1, 32'h18, 4'b0000, 0, 4'd0, 0, 1'b1, 4'd6);
        applyStimulus(0, 32'h0, 4'd0, 0, 4'd0, 0, 1'b0, 4'd0);
        applyStimulus(0, 32'h0, 4'd0, 0, 4'd0, 0, 1'b0, 4'd0);

        // Test 5: reset, abort the sweep at init cycle 9, full 16-cycle restart.
        reset4 = 1'b1;
        @(negedge clk);
        checkReset4();
        reset4 = 1'b0;
        repeat (9) @(negedge clk);
        checkOutput("midinit_ready", 32'(bus4.ready), 32'd0);
        reset4 = 1'b1;
        @(negedge clk);
        checkReset4();
        reset4 = 1'b0;
        checkInit4();
        applyStimulus(1, 32'h14, 4'b0011, 0, 4'd0, 0, 1'b0, 4'd6);
        applyStimulus(0, 32'h0, 4'd0, 0, 4'd0, 0, 1'b0, 4'd0);
        applyStimulus(0, 32'h0, 4'd0, 0, 4'd0, 0, 1'b0, 4'd0);

        // Test 6: N=9 randomised traffic against the counter model.
        reset9 = 1'b0;
        cnt = 0;
        while (bus9.ready !== 1'b1 && cnt < 600) begin
            checkOutput("init9_no_valid", 32'(bus9.pred_valid), 32'd0);
            @(negedge clk);
            cnt++;
        end
        checkOutput("init9_cycles", 32'(cnt), 32'd512);
        for (int i = 0; i < 512; i++) m9[i] = 2'b01;
        for (int c = 0; c < 10000; c++) begin
            req  = 1'($urandom_range(0, 1));
            upd  = 1'($urandom_range(0, 1));
            utk  = 1'($urandom_range(0, 1));
            pc   = $urandom & 32'h0000_00FC;
            hist = 9'($urandom_range(0, 7));
            idx  = pc[10:2] ^ hist;
            uidx = ($urandom_range(0, 3) == 0) ? idx : 9'($urandom_range(0, 63));
            if (upd) m9[uidx] = satNext(m9[uidx], utk);
            if (req) q9.push_back('{taken: m9[idx][1], index: idx});
            bus9.pred_req = req; bus9.pred_pc = pc; bus9.pred_history = hist;
            bus9.upd_valid = upd; bus9.upd_index = uidx; bus9.upd_taken = utk;
            @(negedge clk);
        end
        bus9.pred_req = 1'b0; bus9.upd_valid = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("q4_drained", 32'(q4.size()), 32'd0);
        checkOutput("q9_drained", 32'(q9.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
